cross_bar_slave_ram: RTL and testbench
======================================

// Module: cross_bar_slave_ram
// PURPOSE
//  Slave-side responder for the cross-bar request/ack protocol: accepts one
//  request at a time, waits a fixed number of cycles, then acks it, performing
//  a word write or returning read data. Sits on a slave port of the cross bar as
//  the memory target and as the reference responder for master-side benches.
// PARAMETERS
//  MEM_WORDS    256          storage depth in DATA_WIDTH words (power of 2)
//  BASE_ADDR    32'h0000_0000 byte address of word 0 (MEM_WORDS*4 aligned)
//  WAIT_CYCLES  2            idle cycles between request capture and ack (0..15)
//  OOR_RDATA    32'hDEAD_BEEF read data for out-of-range addresses
// PORTS
//  _clk        in   1           clock, all logic on rising edge
//  _rst        in   1           synchronous reset, active-high
//  _req        in   1           request valid; held by master until _ack
//  _addr       in   ADDR_WIDTH  byte address; [1:0] ignored
//  _cmd        in   1           0 = read, 1 = write
//  _wdata      in   DATA_WIDTH  write data
//  _ack        out  1           one-cycle completion pulse
//  _rdata      out  DATA_WIDTH  read data, valid only while _ack=1
//  _proto_err  out  1           sticky: master dropped/changed request before ack
// BEHAVIOUR
//  Signal set and direction match the slave modport of cross_bar_if;
//  ADDR_WIDTH/DATA_WIDTH come from package interface_connection.
//  Reset (_rst=1 at an edge): state->IDLE, _ack=0, _rdata=0, _proto_err=0,
//   capture regs cleared. Storage array is NOT reset; contents persist.
//  Reset mid-transaction aborts it: no ack, no write.
//  FSM IDLE -> WAIT -> ACK -> IDLE:
//   IDLE: on edge with _req=1 capture addr/cmd/wdata; go WAIT (WAIT_CYCLES>0)
//         or ACK (WAIT_CYCLES=0). Wait counter loaded with WAIT_CYCLES-1.
//   WAIT: decrement counter each edge; at 0 go ACK.
//   ACK:  _ack=1 this cycle only; next state IDLE.
//  Latency: _req first high in cycle N -> _ack high in cycle N+1+WAIT_CYCLES.
//  Throughput: one transaction per WAIT_CYCLES+2 cycles; the cycle after ACK
//   is IDLE and samples _req as a NEW request (back-to-back supported).
//  Write: array updated at the edge ending the ACK cycle, using captured
//   values; a read issued next sees the new data.
//  Read: _rdata registered on entry to ACK from array[captured index];
//   _rdata=0 in every cycle with _ack=0.
//  Range: in-range iff (addr-BASE_ADDR) < MEM_WORDS*4 (unsigned, wraps);
//   index=(addr-BASE_ADDR)[$clog2(MEM_WORDS)+1:2]. Out of range: still acked,
//   write dropped, read returns OOR_RDATA.
//  Protocol check: in WAIT or ACK, _req=0 or addr/cmd/wdata != captured sets
//   _proto_err (sticky until reset); transaction still completes with
//   captured values.
// STRUCTURE
//  Package interface_connection gains: cmd_e {CMD_READ=1'b0, CMD_WRITE=1'b1},
//   slave_state_e {ST_IDLE, ST_WAIT, ST_ACK}, WORD_BYTES=4.
//  Sub-module cross_bar_slave_mem: MEM_WORDS x DATA_WIDTH array, one sync
//   write port, one sync read port, no reset. Top holds FSM, counter, capture,
//   range check, protocol check.
// TESTING
//  1 Reset: _rst 3 cycles with _req=1 -> _ack=0, _rdata=0, _proto_err=0 throughout.
//  2 Write 0x0000_0010 <- 0x1234_5678, then read 0x10 (WAIT_CYCLES=2) -> each
//    _ack exactly 3 cycles after _req rises; read _rdata=0x1234_5678 in ack cycle.
//  3 Back-to-back: write 0x4<-0xA, write 0x8<-0xB, read 0x4, read 0x8, _req held
//    high throughout -> 4 acks spaced 4 cycles apart; reads return 0xA, 0xB.
//  4 Out of range: write 0x400<-0x1 then read 0x400 (MEM_WORDS=256) -> both acked,
//    read returns 0xDEAD_BEEF; read 0x0 unchanged.
//  5 Protocol: drop _req in WAIT -> _ack still pulses at N+3, _proto_err=1
//    and stays 1 until _rst.
//  6 Reset mid-transaction: _rst in WAIT of write 0x20<-0x55 -> no ack; later
//    read 0x20 returns prior content; WAIT_CYCLES=0 build acks in cycle N+1.

Source files
------------

// File: rtl/cross_bar_slave_ram_pkg.sv
// Shared definitions for the cross-bar request/ack protocol.
//   ADDR_WIDTH / DATA_WIDTH : bus widths used by masters and slaves
//   WORD_BYTES              : bytes per storage word
//   cmd_e                   : request command encoding
//   slave_state_e           : slave responder FSM states
package interface_connection;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } slave_state_e;

endpackage

// File: rtl/cross_bar_slave_ram_mem.sv
// Word storage for the slave RAM responder. No reset: contents persist.
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i sampled on the rising edge
//   re_i    : read enable, rdata_o updated from raddr_i on the rising edge
//   rdata_o : registered read data
module cross_bar_slave_mem #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [IDX_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cross_bar_slave_ram.sv
// Slave-side RAM responder for the cross-bar request/ack protocol. Accepts one
// request at a time, waits WAIT_CYCLES cycles, then pulses ack for one cycle,
// performing a word write or returning read data.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset (storage not cleared)
//   req_i       : request valid, held by the master until ack_o
//   addr_i      : byte address, bits [1:0] ignored
//   cmd_i       : 0 = read, 1 = write
//   wdata_i     : write data
//   ack_o       : one-cycle completion pulse
//   rdata_o     : read data, zero whenever ack_o is low
//   proto_err_o : sticky flag, master dropped/changed request before ack
module cross_bar_slave_ram
  import interface_connection::*;
#(
  parameter int unsigned           MEM_WORDS   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] OOR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  cmd_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  proto_err_o
);

  localparam int unsigned           IdxW      = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] SpanBytes = ADDR_WIDTH'(MEM_WORDS * WORD_BYTES);
  localparam logic [3:0]            WaitLoad  = (WAIT_CYCLES == 0) ? 4'd0
                                                                   : 4'(WAIT_CYCLES - 1);

  // Offset arithmetic wraps, so addresses below BASE_ADDR land out of range.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off < SpanBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[IdxW+1:2];
  endfunction

  slave_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  cmd_e                  cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  perr_q, perr_d;

  logic                  mem_we, mem_re;
  logic [IdxW-1:0]       mem_waddr, mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          cmd_d   = cmd_e'(cmd_i);
          wdata_d = wdata_i;
          cnt_d   = WaitLoad;
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The master must hold the request unchanged until it sees ack.
    if (state_q != ST_IDLE &&
        (!req_i || addr_i != addr_q || cmd_e'(cmd_i) != cmd_q || wdata_i != wdata_q)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      cmd_q   <= CMD_READ;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  // Read port fires on entry to ACK. With no wait states that entry happens
  // straight from IDLE, before the capture registers hold the address.
  assign mem_raddr = (state_q == ST_IDLE) ? word_index(addr_i) : word_index(addr_q);
  assign mem_re    = (state_d == ST_ACK) && !rst_i;

  // Write commits at the edge ending ACK; a reset on that edge aborts it.
  assign mem_waddr = word_index(addr_q);
  assign mem_we    = (state_q == ST_ACK) && (cmd_q == CMD_WRITE) &&
                     addr_in_range(addr_q) && !rst_i;

  cross_bar_slave_mem #(
    .MEM_WORDS  (MEM_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IdxW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (wdata_q),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign ack_o       = (state_q == ST_ACK);
  assign rdata_o     = (state_q == ST_ACK && cmd_q == CMD_READ)
                       ? (addr_in_range(addr_q) ? mem_rdata : OOR_RDATA)
                       : '0;
  assign proto_err_o = perr_q;

endmodule

// File: tb/tb_cross_bar_slave_ram.sv
// Self-checking bench for cross_bar_slave_ram. Two instances: WAIT_CYCLES=2
// (index 0) and WAIT_CYCLES=0 (index 1). A timestamp-based transaction model
// predicts ack/rdata/proto_err every cycle; directed tests pin latencies and
// read data with literal values.
module tb_cross_bar_slave_ram;
  import interface_connection::*;

  localparam logic [31:0] Oor = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r   [2];
  logic        req_r   [2];
  logic [31:0] addr_r  [2];
  logic        cmd_r   [2];
  logic [31:0] wdata_r [2];
  logic        ack_w   [2];
  logic [31:0] rdata_w [2];
  logic        perr_w  [2];

  cross_bar_slave_ram #(
    .MEM_WORDS   (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (2),
    .OOR_RDATA   (32'hDEAD_BEEF)
  ) u_dut0 (
    .clk_i       (clk),
    .rst_i       (rst_r[0]),
    .req_i       (req_r[0]),
    .addr_i      (addr_r[0]),
    .cmd_i       (cmd_r[0]),
    .wdata_i     (wdata_r[0]),
    .ack_o       (ack_w[0]),
    .rdata_o     (rdata_w[0]),
    .proto_err_o (perr_w[0])
  );

  cross_bar_slave_ram #(
    .MEM_WORDS   (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (0),
    .OOR_RDATA   (32'hDEAD_BEEF)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst_r[1]),
    .req_i       (req_r[1]),
    .addr_i      (addr_r[1]),
    .cmd_i       (cmd_r[1]),
    .wdata_i     (wdata_r[1]),
    .ack_o       (ack_w[1]),
    .rdata_o     (rdata_w[1]),
    .proto_err_o (perr_w[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'd1024;  // 256 words * 4 bytes from base 0
  endfunction

  function automatic int mkey(input int d, input logic [31:0] a);
    return d * 1024 + int'((a >> 2) & 32'hFF);
  endfunction

  // Transaction model: a request accepted in cycle c acks in cycle c+1+W.
  bit          m_valid [2] = '{0, 0};
  bit          m_busy  [2] = '{0, 0};
  longint      m_ack_at[2];
  logic [31:0] m_addr  [2];
  logic        m_cmd   [2];
  logic [31:0] m_wdata [2];
  bit          m_perr  [2] = '{0, 0};
  logic [31:0] m_mem   [int];
  longint      mcyc = 0;

  always @(negedge clk) begin
    bit eack;
    int k;
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d]) begin
        eack = m_busy[d] && (mcyc == m_ack_at[d]);
        check("ack", d, {31'd0, ack_w[d]}, {31'd0, eack});
        if (!eack) begin
          check("rdata_idle", d, rdata_w[d], 32'd0);
        end else if (m_cmd[d] == 1'b0) begin
          k = mkey(d, m_addr[d]);
          if (!in_rng(m_addr[d])) check("rdata_oor", d, rdata_w[d], Oor);
          else if (m_mem.exists(k)) check("rdata", d, rdata_w[d], m_mem[k]);
        end
        check("proto_err", d, {31'd0, perr_w[d]}, {31'd0, m_perr[d]});
      end
      if (rst_r[d]) begin
        m_busy[d]  = 0;
        m_perr[d]  = 0;
        m_valid[d] = 1;
      end else if (m_busy[d]) begin
        if (!req_r[d] || addr_r[d] != m_addr[d] || cmd_r[d] != m_cmd[d] ||
            wdata_r[d] != m_wdata[d]) m_perr[d] = 1;
        if (mcyc == m_ack_at[d]) begin
          if (m_cmd[d] && in_rng(m_addr[d])) m_mem[mkey(d, m_addr[d])] = m_wdata[d];
          m_busy[d] = 0;
        end
      end else if (req_r[d]) begin
        m_busy[d]   = 1;
        m_ack_at[d] = mcyc + 1 + longint'(wait_of(d));
        m_addr[d]   = addr_r[d];
        m_cmd[d]    = cmd_r[d];
        m_wdata[d]  = wdata_r[d];
      end
    end
    mcyc++;
  end

  // Called at posedge+1; presents a request, waits for ack, returns at
  // posedge+1 of the cycle after ack with the request still driven.
  task automatic txn(input int d, input logic [31:0] a, input logic c,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output longint t);
    req_r[d] = 1'b1; addr_r[d] = a; cmd_r[d] = c; wdata_r[d] = wd;
    lat = -1; rd = '0; t = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack_w[d] === 1'b1) begin
        lat = k; rd = rdata_w[d]; t = longint'($time);
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout dut%0d addr %h: got no ack, expected one", d, a);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    req_r[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] rd;
    longint t0, t1, t2, t3;

    for (int d = 0; d < 2; d++) begin
      rst_r[d] = 1'b1; req_r[d] = 1'b1; addr_r[d] = 32'h10;
      cmd_r[d] = 1'b1; wdata_r[d] = 32'hFFFF_FFFF;
    end

    // 1: reset with req high
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", 0, {31'd0, ack_w[0]}, 32'd0);
      check("rst_rdata", 0, rdata_w[0], 32'd0);
      check("rst_perr", 0, {31'd0, perr_w[0]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      rst_r[d] = 1'b0; req_r[d] = 1'b0;
    end
    idle(0, 2);

    // 2: write then read
    txn(0, 32'h10, 1'b1, 32'h1234_5678, lat, rd, t0);
    check("wr_lat", 0, 32'(lat), 32'd3);
    txn(0, 32'h10, 1'b0, 32'h0, lat, rd, t0);
    check("rd_lat", 0, 32'(lat), 32'd3);
    check("rd_data", 0, rd, 32'h1234_5678);
    idle(0, 2);

    // 3: back-to-back, req held high
    txn(0, 32'h4, 1'b1, 32'hA, lat, rd, t0);
    txn(0, 32'h8, 1'b1, 32'hB, lat, rd, t1);
    txn(0, 32'h4, 1'b0, 32'h0, lat, rd, t2);
    check("b2b_rd4", 0, rd, 32'hA);
    txn(0, 32'h8, 1'b0, 32'h0, lat, rd, t3);
    check("b2b_rd8", 0, rd, 32'hB);
    check("b2b_gap1", 0, 32'((t1 - t0) / 10), 32'd4);
    check("b2b_gap2", 0, 32'((t2 - t1) / 10), 32'd4);
    check("b2b_gap3", 0, 32'((t3 - t2) / 10), 32'd4);
    idle(0, 2);

    // 4: out of range (0x400 would alias word 0 without the range check)
    txn(0, 32'h0, 1'b1, 32'h5A5A_0001, lat, rd, t0);
    txn(0, 32'h400, 1'b1, 32'h1, lat, rd, t0);
    check("oor_wr_lat", 0, 32'(lat), 32'd3);
    txn(0, 32'h400, 1'b0, 32'h0, lat, rd, t0);
    check("oor_rd", 0, rd, 32'hDEAD_BEEF);
    txn(0, 32'h0, 1'b0, 32'h0, lat, rd, t0);
    check("rd0_kept", 0, rd, 32'h5A5A_0001);
    idle(0, 2);

    // 5: drop req in WAIT
    req_r[0] = 1'b1; addr_r[0] = 32'h4; cmd_r[0] = 1'b0; wdata_r[0] = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    req_r[0] = 1'b0;
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (ack_w[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("perr_ack_lat", 0, 32'(lat), 32'd3);
    idle(0, 3);
    check("perr_set", 0, {31'd0, perr_w[0]}, 32'd1);
    txn(0, 32'h4, 1'b0, 32'h0, lat, rd, t0);
    check("perr_rd", 0, rd, 32'hA);
    idle(0, 1);
    check("perr_sticky", 0, {31'd0, perr_w[0]}, 32'd1);
    rst_r[0] = 1'b1;
    @(posedge clk); #1;
    rst_r[0] = 1'b0;
    @(negedge clk);
    check("perr_clr", 0, {31'd0, perr_w[0]}, 32'd0);
    @(posedge clk); #1;

    // 6: reset in WAIT of a write aborts it
    txn(0, 32'h20, 1'b1, 32'h77, lat, rd, t0);
    idle(0, 1);
    req_r[0] = 1'b1; addr_r[0] = 32'h20; cmd_r[0] = 1'b1; wdata_r[0] = 32'h55;
    @(posedge clk); #1;
    rst_r[0] = 1'b1;
    @(posedge clk); #1;
    rst_r[0] = 1'b0; req_r[0] = 1'b0;
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_w[0] === 1'b1) lat++;
    end
    check("abort_no_ack", 0, 32'(lat), 32'd0);
    @(posedge clk); #1;
    txn(0, 32'h20, 1'b0, 32'h0, lat, rd, t0);
    check("abort_rd", 0, rd, 32'h77);
    idle(0, 1);

    // WAIT_CYCLES=0 instance
    txn(1, 32'h8, 1'b1, 32'h33, lat, rd, t0);
    check("w0_wr_lat", 1, 32'(lat), 32'd1);
    txn(1, 32'h8, 1'b0, 32'h0, lat, rd, t1);
    check("w0_rd_lat", 1, 32'(lat), 32'd1);
    check("w0_rd", 1, rd, 32'h33);
    check("w0_gap", 1, 32'((t1 - t0) / 10), 32'd2);
    txn(1, 32'h400, 1'b0, 32'h0, lat, rd, t0);
    check("w0_oor", 1, rd, 32'hDEAD_BEEF);
    idle(1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
